// File: rtl/aer_out_core_merger.sv
// Merges AER events from a CORE_W x CORE_H core array onto one 4-phase bus.
// Spikes are remapped to global {c, y, x}; per-core control events are folded into a single barrier.
module aer_out_core_merger #(
    parameter int CORE_W         = 16,
    parameter int CORE_H         = 16,
    parameter int CORE_C         = 3,
    parameter int CORE_AER_WIDTH = 12,
    parameter int OUT_AER_WIDTH  = 12
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [CORE_W*CORE_H-1:0]                       CORE_OUT_AEROUT_REQ,
    input  logic [CORE_W*CORE_H-1:0][CORE_AER_WIDTH-1:0]   CORE_OUT_AEROUT_EVENT,
    output logic [CORE_W*CORE_H-1:0]                       CORE_OUT_AEROUT_ACK,
    output logic                                           MERGE_OUT_AEROUT_REQ,
    output logic [OUT_AER_WIDTH-1:0]                       MERGE_OUT_AEROUT_EVENT,
    output logic [OUT_AER_WIDTH-3:0]                       MERGE_OUT_AEROUT_IDX,
    input  logic                                           MERGE_OUT_AEROUT_ACK,
    output logic                                           BARRIER_ERR
);

    localparam int N      = CORE_W * CORE_H;
    localparam int C_BITS = (CORE_C > 1) ? $clog2(CORE_C) : 1;
    localparam int Y_BITS = (CORE_H > 1) ? $clog2(CORE_H) : 1;
    localparam int X_BITS = (CORE_W > 1) ? $clog2(CORE_W) : 1;
    localparam int PTR_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W  = OUT_AER_WIDTH - 2;

    localparam logic [1:0] T_SPIKE   = 2'b00;
    localparam logic [1:0] T_INVALID = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CACK,
        S_OREQ,
        S_OREL
    } state_t;

    state_t                    state_reg;
    logic [PTR_W-1:0]          rr_reg;
    logic [PTR_W-1:0]          grant_reg;
    logic [CORE_AER_WIDTH-1:0] event_reg;
    logic [N-1:0]              mask_reg;
    logic [1:0]                btype_reg;
    logic [N-1:0]              ack_reg;
    logic                      mreq_reg;
    logic [OUT_AER_WIDTH-1:0]  mevent_reg;
    logic [IDX_W-1:0]          midx_reg;
    logic                      err_reg;

    // Round-robin search: split eligible cores into those at/above the pointer and the rest
    logic [N-1:0] elig;
    logic [N-1:0] elig_hi;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elig
            assign elig[gi]    = CORE_OUT_AEROUT_REQ[gi] & ~mask_reg[gi];
            assign elig_hi[gi] = elig[gi] & (PTR_W'(gi) >= rr_reg);
        end
    endgenerate

    logic             pick_any;
    logic [PTR_W-1:0] pick_lo;
    logic [PTR_W-1:0] pick_hi;
    logic [PTR_W-1:0] pick_next;
    logic [PTR_W-1:0] rr_next;
    logic [N-1:0]     pick_onehot;

    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i])    pick_lo = PTR_W'(i);
            if (elig_hi[i]) pick_hi = PTR_W'(i);
        end
        pick_any    = |elig;
        pick_next   = (|elig_hi) ? pick_hi : pick_lo;
        rr_next     = (pick_next == PTR_W'(N - 1)) ? '0 : pick_next + PTR_W'(1);
        pick_onehot = {{(N-1){1'b0}}, 1'b1} << pick_next;
    end

    // Decode of the latched event against the granted core position
    logic [1:0]        ev_type;
    logic [C_BITS-1:0] ev_c;
    logic [Y_BITS-1:0] g_y;
    logic [X_BITS-1:0] g_x;
    logic [IDX_W-1:0]  spike_idx;
    logic [N-1:0]      grant_onehot;
    logic [N-1:0]      mask_set;
    logic              first_ctrl;
    logic [1:0]        bar_type;
    logic              unused_event;

    always_comb begin
        ev_type      = event_reg[CORE_AER_WIDTH-1 -: 2];
        ev_c         = event_reg[C_BITS-1:0];
        g_y          = Y_BITS'(int'(grant_reg) / CORE_W);
        g_x          = X_BITS'(int'(grant_reg) % CORE_W);
        spike_idx    = IDX_W'({ev_c, g_y, g_x});
        grant_onehot = {{(N-1){1'b0}}, 1'b1} << grant_reg;
        mask_set     = mask_reg | grant_onehot;
        first_ctrl   = (mask_reg == '0);
        bar_type     = first_ctrl ? ev_type : btype_reg;
    end

    assign unused_event = ^event_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            rr_reg     <= '0;
            grant_reg  <= '0;
            event_reg  <= '0;
            mask_reg   <= '0;
            btype_reg  <= '0;
            ack_reg    <= '0;
            mreq_reg   <= 1'b0;
            mevent_reg <= '0;
            midx_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_reg <= pick_next;
                        event_reg <= CORE_OUT_AEROUT_EVENT[pick_next];
                        rr_reg    <= rr_next;
                        ack_reg   <= pick_onehot;
                        state_reg <= S_CACK;
                    end
                end
                S_CACK: begin
                    if (!CORE_OUT_AEROUT_REQ[grant_reg]) begin
                        ack_reg <= '0;
                        case (ev_type)
                            T_SPIKE: begin
                                mevent_reg <= {T_SPIKE, spike_idx};
                                midx_reg   <= spike_idx;
                                mreq_reg   <= 1'b1;
                                state_reg  <= S_OREQ;
                            end
                            T_INVALID: state_reg <= S_IDLE;
                            default: begin
                                // The first arrival of a barrier round fixes its type
                                if (first_ctrl)
                                    btype_reg <= ev_type;
                                else if (ev_type != btype_reg)
                                    err_reg <= 1'b1;
                                if (&mask_set) begin
                                    mask_reg   <= '0;
                                    mevent_reg <= {bar_type, {IDX_W{1'b1}}};
                                    midx_reg   <= '0;
                                    mreq_reg   <= 1'b1;
                                    state_reg  <= S_OREQ;
                                end else begin
                                    mask_reg  <= mask_set;
                                    state_reg <= S_IDLE;
                                end
                            end
                        endcase
                    end
                end
                S_OREQ: begin
                    if (MERGE_OUT_AEROUT_ACK) begin
                        mreq_reg  <= 1'b0;
                        state_reg <= S_OREL;
                    end
                end
                S_OREL: begin
                    if (!MERGE_OUT_AEROUT_ACK) state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign CORE_OUT_AEROUT_ACK    = ack_reg;
    assign MERGE_OUT_AEROUT_REQ   = mreq_reg;
    assign MERGE_OUT_AEROUT_EVENT = mevent_reg;
    assign MERGE_OUT_AEROUT_IDX   = midx_reg;
    assign BARRIER_ERR            = err_reg;

endmodule
